// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sound_sequencer
//  Description : Drives the single speaker output. Plays live colour tones
//                from the game controller, and otherwise plays latched
//                4-note event jingles (start, win, lose, high score) in
//                priority order LOSE > WIN > HS > START.
//  Revision    : 1.0 - initial release
// ============================================================================
module sound_sequencer #(
   parameter int               DIV_W    = 16,
   parameter int               LEN_W    = 21,
   parameter logic [DIV_W-1:0] HALF_P0  = 16'd22727,
   parameter logic [DIV_W-1:0] HALF_P1  = 16'd18029,
   parameter logic [DIV_W-1:0] HALF_P2  = 16'd15152,
   parameter logic [DIV_W-1:0] HALF_P3  = 16'd11364,
   parameter logic [LEN_W-1:0] NOTE_LEN = 21'd1500000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       TONE_ENA,
   input  logic [1:0] TONE_SEL,
   input  logic       START_SND,
   input  logic       WIN_SND,
   input  logic       LOSE_SND,
   input  logic       HS_SND,
   output logic       SPK,
   output logic       BUSY
);

   // Pending-bit / jingle identifiers
   localparam logic [1:0] c_jid_start = 2'd0;
   localparam logic [1:0] c_jid_win   = 2'd1;
   localparam logic [1:0] c_jid_lose  = 2'd2;
   localparam logic [1:0] c_jid_hs    = 2'd3;

   // Note tables, note n in bits [2n+1:2n]
   localparam logic [7:0] c_rom_start = 8'hE4;   // 0,1,2,3
   localparam logic [7:0] c_rom_win   = 8'hEE;   // 2,3,2,3
   localparam logic [7:0] c_rom_lose  = 8'h1B;   // 3,2,1,0
   localparam logic [7:0] c_rom_hs    = 8'h88;   // 0,2,0,2

   localparam logic [DIV_W-1:0] c_div_one  = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] c_len_load = NOTE_LEN - c_len_one;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TONE   = 2'd1,
      ST_JINGLE = 2'd2
   } state_t;

   state_t           r_state,    w_state_nxt;
   logic [3:0]       r_pending,  w_pending_nxt;
   logic [1:0]       r_jingle,   w_jingle_nxt;
   logic [1:0]       r_note,     w_note_nxt;
   logic [LEN_W-1:0] r_len,      w_len_nxt;
   logic [DIV_W-1:0] r_div,      w_div_nxt;
   logic             r_spk,      w_spk_nxt;
   logic [1:0]       r_tone_sel, w_tone_sel_nxt;
   logic             r_busy;

   logic [3:0]       w_req;
   logic [3:0]       w_clear;
   logic [1:0]       w_pick;
   logic             w_load;
   logic [1:0]       w_load_idx;
   logic             w_run;
   logic [1:0]       w_run_idx;
   logic             w_silence;

   function automatic logic [DIV_W-1:0] f_half(input logic [1:0] idx);
      case (idx)
         2'd0:    f_half = HALF_P0;
         2'd1:    f_half = HALF_P1;
         2'd2:    f_half = HALF_P2;
         default: f_half = HALF_P3;
      endcase
   endfunction

   function automatic logic [1:0] f_rom(input logic [1:0] jid, input logic [1:0] note);
      logic [7:0] tbl;
      logic [7:0] sh;
      case (jid)
         c_jid_start: tbl = c_rom_start;
         c_jid_win:   tbl = c_rom_win;
         c_jid_lose:  tbl = c_rom_lose;
         default:     tbl = c_rom_hs;
      endcase
      sh    = tbl >> {note, 1'b0};
      f_rom = sh[1:0];
   endfunction

   assign w_req = {HS_SND, LOSE_SND, WIN_SND, START_SND};

   // Highest-priority pending jingle: LOSE > WIN > HS > START
   always_comb begin
      w_pick = c_jid_start;
      if (r_pending[c_jid_lose])     w_pick = c_jid_lose;
      else if (r_pending[c_jid_win]) w_pick = c_jid_win;
      else if (r_pending[c_jid_hs])  w_pick = c_jid_hs;
   end

   // Next-state, sequencing and square-wave generator
   always_comb begin
      w_state_nxt    = r_state;
      w_jingle_nxt   = r_jingle;
      w_note_nxt     = r_note;
      w_len_nxt      = r_len;
      w_tone_sel_nxt = r_tone_sel;
      w_clear        = 4'b0000;
      w_load         = 1'b0;
      w_load_idx     = TONE_SEL;
      w_run          = 1'b0;
      w_run_idx      = r_tone_sel;
      w_silence      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_silence = 1'b1;
            if (TONE_ENA) begin
               w_state_nxt    = ST_TONE;
               w_load         = 1'b1;
               w_load_idx     = TONE_SEL;
               w_tone_sel_nxt = TONE_SEL;
            end else if (|r_pending) begin
               w_state_nxt  = ST_JINGLE;
               w_jingle_nxt = w_pick;
               w_note_nxt   = 2'd0;
               w_len_nxt    = c_len_load;
               w_clear      = 4'b0001 << w_pick;
               w_load       = 1'b1;
               w_load_idx   = f_rom(w_pick, 2'd0);
            end
         end
         ST_TONE: begin
            if (!TONE_ENA) begin
               w_state_nxt = ST_IDLE;
               w_silence   = 1'b1;
            end else if (TONE_SEL != r_tone_sel) begin
               w_load         = 1'b1;
               w_load_idx     = TONE_SEL;
               w_tone_sel_nxt = TONE_SEL;
            end else begin
               w_run     = 1'b1;
               w_run_idx = r_tone_sel;
            end
         end
         ST_JINGLE: begin
            if (TONE_ENA) begin
               // Live tone pre-empts; the aborted jingle is dropped
               w_state_nxt    = ST_TONE;
               w_load         = 1'b1;
               w_load_idx     = TONE_SEL;
               w_tone_sel_nxt = TONE_SEL;
            end else if (r_len == '0) begin
               if (r_note != 2'd3) begin
                  w_note_nxt = r_note + 2'd1;
                  w_len_nxt  = c_len_load;
                  w_load     = 1'b1;
                  w_load_idx = f_rom(r_jingle, r_note + 2'd1);
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_silence   = 1'b1;
               end
            end else begin
               w_len_nxt = r_len - c_len_one;
               w_run     = 1'b1;
               w_run_idx = f_rom(r_jingle, r_note);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_silence   = 1'b1;
         end
      endcase

      // A same-cycle request for the jingle being started keeps its bit set
      w_pending_nxt = (r_pending & ~w_clear) | w_req;

      w_spk_nxt = r_spk;
      w_div_nxt = r_div;
      if (w_load) begin
         w_spk_nxt = 1'b1;
         w_div_nxt = f_half(w_load_idx) - c_div_one;
      end else if (w_run) begin
         if (r_div == '0) begin
            w_spk_nxt = ~r_spk;
            w_div_nxt = f_half(w_run_idx) - c_div_one;
         end else begin
            w_div_nxt = r_div - c_div_one;
         end
      end else if (w_silence) begin
         w_spk_nxt = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= ST_IDLE;
         r_pending  <= 4'b0000;
         r_jingle   <= 2'd0;
         r_note     <= 2'd0;
         r_len      <= '0;
         r_div      <= '0;
         r_spk      <= 1'b0;
         r_tone_sel <= 2'd0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pending  <= w_pending_nxt;
         r_jingle   <= w_jingle_nxt;
         r_note     <= w_note_nxt;
         r_len      <= w_len_nxt;
         r_div      <= w_div_nxt;
         r_spk      <= w_spk_nxt;
         r_tone_sel <= w_tone_sel_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE) || (|w_pending_nxt);
      end
   end

   assign SPK  = r_spk;
   assign BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sound_sequencer
//  Description : Self-checking bench for sound_sequencer with a time-based
//                behavioural model (tone phase derived from elapsed cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_sequencer;

   localparam int NL = 20;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       TONE_ENA = 1'b0;
   logic [1:0] TONE_SEL = 2'd0;
   logic       START_SND = 1'b0;
   logic       WIN_SND = 1'b0;
   logic       LOSE_SND = 1'b0;
   logic       HS_SND = 1'b0;
   logic       SPK;
   logic       BUSY;

   int n_tests = 0;
   int n_fail  = 0;

   sound_sequencer #(
      .DIV_W(16), .LEN_W(21),
      .HALF_P0(16'd2), .HALF_P1(16'd3), .HALF_P2(16'd4), .HALF_P3(16'd5),
      .NOTE_LEN(21'd20)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .TONE_ENA(TONE_ENA), .TONE_SEL(TONE_SEL),
      .START_SND(START_SND), .WIN_SND(WIN_SND), .LOSE_SND(LOSE_SND),
      .HS_SND(HS_SND), .SPK(SPK), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   // jingle ids: 0 START, 1 WIN, 2 LOSE, 3 HS
   function automatic int half(input int i);
      return i + 2;
   endfunction

   function automatic int rom(input int j, input int n);
      int r [4];
      case (j)
         0: r = '{0, 1, 2, 3};
         1: r = '{2, 3, 2, 3};
         2: r = '{3, 2, 1, 0};
         default: r = '{0, 2, 0, 2};
      endcase
      return r[n];
   endfunction

   function automatic int pick(input bit [3:0] p);
      if (p[2]) return 2;
      if (p[1]) return 1;
      if (p[3]) return 3;
      return 0;
   endfunction

   int       m_mode = 0;   // 0 idle, 1 tone, 2 jingle
   bit [3:0] m_pend = 0;
   bit [3:0] m_req;
   int       m_jid = 0;
   int       m_t = 0;      // cycles since current sound was loaded
   int       m_sel = 0;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_mode = 0;
         m_pend = 0;
         m_t    = 0;
      end else begin
         m_req = {HS_SND, LOSE_SND, WIN_SND, START_SND};
         case (m_mode)
            0: begin
               if (TONE_ENA) begin
                  m_mode = 1; m_t = 0; m_sel = int'(TONE_SEL);
               end else if (m_pend != 0) begin
                  m_jid = pick(m_pend);
                  m_pend[m_jid] = 1'b0;
                  m_mode = 2; m_t = 0;
               end
            end
            1: begin
               if (!TONE_ENA) m_mode = 0;
               else if (int'(TONE_SEL) != m_sel) begin
                  m_sel = int'(TONE_SEL); m_t = 0;
               end else m_t++;
            end
            default: begin
               if (TONE_ENA) begin
                  m_mode = 1; m_t = 0; m_sel = int'(TONE_SEL);
               end else if (m_t == 4 * NL - 1) m_mode = 0;
               else m_t++;
            end
         endcase
         m_pend = m_pend | m_req;
      end
   end

   function automatic logic exp_spk();
      int u;
      if (m_mode == 1) return ((m_t / half(m_sel)) % 2) == 0;
      if (m_mode == 2) begin
         u = m_t % NL;
         return ((u / half(rom(m_jid, m_t / NL))) % 2) == 0;
      end
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      check("spk_model", {31'd0, SPK}, {31'd0, exp_spk()});
      check("busy_model", {31'd0, BUSY}, {31'd0, (m_mode != 0) || (m_pend != 0)});
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cnt_busy;
      int cnt_spk;
      int hold;

      tick(3);
      check("reset_spk", {31'd0, SPK}, 32'd0);
      check("reset_busy", {31'd0, BUSY}, 32'd0);
      RST_N = 1'b1;
      tick(2);

      // 1: tone index 2, half period 4
      TONE_ENA = 1'b1; TONE_SEL = 2'd2;
      tick(1);
      for (int i = 0; i < 8; i++) begin
         check("tone_wave", {31'd0, SPK}, (i < 4) ? 32'd1 : 32'd0);
         tick(1);
      end
      tick(32);
      TONE_ENA = 1'b0;
      tick(1);
      check("tone_off_spk", {31'd0, SPK}, 32'd0);
      check("tone_off_busy", {31'd0, BUSY}, 32'd0);
      tick(3);

      // 2: LOSE jingle, 81 busy cycles, 10+12+11+10 high cycles
      LOSE_SND = 1'b1;
      tick(1);
      LOSE_SND = 1'b0;
      check("lose_busy_next", {31'd0, BUSY}, 32'd1);
      cnt_busy = 0; cnt_spk = 0;
      for (int i = 0; i < 100; i++) begin
         cnt_busy += int'(BUSY); cnt_spk += int'(SPK);
         tick(1);
      end
      check("lose_busy_len", cnt_busy, 32'd81);
      check("lose_spk_high", cnt_spk, 32'd43);
      check("lose_end_busy", {31'd0, BUSY}, 32'd0);

      // 3: three jingles back-to-back, BUSY continuous for 243 cycles
      START_SND = 1'b1; WIN_SND = 1'b1; HS_SND = 1'b1;
      tick(1);
      START_SND = 1'b0; WIN_SND = 1'b0; HS_SND = 1'b0;
      cnt_busy = 0;
      for (int i = 0; i < 300; i++) begin
         cnt_busy += int'(BUSY);
         tick(1);
      end
      check("multi_busy_len", cnt_busy, 32'd243);

      // 4: WIN pre-empted by a tone, not replayed
      WIN_SND = 1'b1;
      tick(1);
      WIN_SND = 1'b0;
      tick(30);
      TONE_ENA = 1'b1; TONE_SEL = 2'd1;
      tick(1);
      check("preempt_spk", {31'd0, SPK}, 32'd1);
      tick(19);
      TONE_ENA = 1'b0;
      tick(3);
      cnt_busy = 0;
      for (int i = 0; i < 100; i++) begin
         cnt_busy += int'(BUSY);
         tick(1);
      end
      check("preempt_no_replay", cnt_busy, 32'd0);

      // 5: HS requested during a tone, starts one cycle after tone ends
      TONE_ENA = 1'b1; TONE_SEL = 2'd0;
      tick(10);
      HS_SND = 1'b1;
      tick(1);
      HS_SND = 1'b0;
      tick(10);
      check("hs_pending_busy", {31'd0, BUSY}, 32'd1);
      TONE_ENA = 1'b0;
      tick(1);
      check("hs_idle_spk", {31'd0, SPK}, 32'd0);
      check("hs_idle_busy", {31'd0, BUSY}, 32'd1);
      tick(1);
      check("hs_start_spk", {31'd0, SPK}, 32'd1);
      tick(90);

      // 6: asynchronous reset mid-jingle with another jingle pending
      LOSE_SND = 1'b1;
      tick(1);
      LOSE_SND = 1'b0;
      tick(5);
      WIN_SND = 1'b1;
      tick(1);
      WIN_SND = 1'b0;
      tick(7);
      #2 RST_N = 1'b0;
      #1;
      check("async_rst_spk", {31'd0, SPK}, 32'd0);
      check("async_rst_busy", {31'd0, BUSY}, 32'd0);
      tick(2);
      RST_N = 1'b1;
      cnt_busy = 0;
      for (int i = 0; i < 100; i++) begin
         cnt_busy += int'(BUSY);
         tick(1);
      end
      check("post_rst_quiet", cnt_busy, 32'd0);

      // Randomized traffic against the model
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            TONE_ENA = ($urandom_range(0, 9) < 3);
            hold = $urandom_range(1, 60);
         end else hold--;
         if ($urandom_range(0, 15) == 0) TONE_SEL = 2'($urandom_range(0, 3));
         START_SND = ($urandom_range(0, 63) == 0);
         WIN_SND   = ($urandom_range(0, 63) == 0);
         LOSE_SND  = ($urandom_range(0, 63) == 0);
         HS_SND    = ($urandom_range(0, 63) == 0);
         tick(1);
      end
      TONE_ENA = 1'b0; START_SND = 1'b0; WIN_SND = 1'b0;
      LOSE_SND = 1'b0; HS_SND = 1'b0;
      tick(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
